// File: rtl/alu_exec_unit.sv
// Execute-stage ALU: single-cycle logic/arithmetic ops plus an iterative
// shift-add multiplier, with valid/ready handshakes on input and output.
module alu_exec_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             ovf,
  output logic             bad_op
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

  localparam logic [3:0] OP_AND = 4'b0000;
  localparam logic [3:0] OP_OR  = 4'b0001;
  localparam logic [3:0] OP_ADD = 4'b0010;
  localparam logic [3:0] OP_SUB = 4'b0110;
  localparam logic [3:0] OP_SLT = 4'b0111;
  localparam logic [3:0] OP_NOR = 4'b1100;
  localparam logic [3:0] OP_MUL = 4'b1000;

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DONE} state_t;

  state_t           state_reg, state_next;
  logic [WIDTH-1:0] result_reg, result_next;
  logic             zero_reg, zero_next;
  logic             ovf_reg, ovf_next;
  logic             bad_reg, bad_next;
  logic [WIDTH-1:0] mcand_reg, mcand_next;
  logic [WIDTH-1:0] mplier_reg, mplier_next;
  logic [WIDTH-1:0] acc_reg, acc_next;
  logic [CW-1:0]    cnt_reg, cnt_next;

  logic             accept;
  logic [WIDTH-1:0] alu_res, sum, diff, mul_sum;
  logic             alu_ovf, alu_bad, is_mul;

  assign in_ready  = (state_reg == S_IDLE) | ((state_reg == S_DONE) & out_ready);
  assign accept    = in_valid & in_ready;
  assign out_valid = (state_reg == S_DONE);
  assign result    = result_reg;
  assign zero      = zero_reg;
  assign ovf       = ovf_reg;
  assign bad_op    = bad_reg;

  assign sum     = a + b;
  assign diff    = a - b;
  assign mul_sum = acc_reg + (mplier_reg[0] ? mcand_reg : '0);

  always_comb begin
    alu_res = '0;
    alu_ovf = 1'b0;
    alu_bad = 1'b0;
    is_mul  = 1'b0;
    case (op)
      OP_AND: alu_res = a & b;
      OP_OR:  alu_res = a | b;
      OP_NOR: alu_res = ~(a | b);
      OP_ADD: begin
        alu_res = sum;
        alu_ovf = (a[WIDTH-1] == b[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
      end
      OP_SUB: begin
        alu_res = diff;
        alu_ovf = (a[WIDTH-1] != b[WIDTH-1]) && (diff[WIDTH-1] != a[WIDTH-1]);
      end
      OP_SLT: alu_res = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
      OP_MUL: is_mul  = 1'b1;
      default: alu_bad = 1'b1;
    endcase
  end

  always_comb begin
    state_next  = state_reg;
    result_next = result_reg;
    zero_next   = zero_reg;
    ovf_next    = ovf_reg;
    bad_next    = bad_reg;
    mcand_next  = mcand_reg;
    mplier_next = mplier_reg;
    acc_next    = acc_reg;
    cnt_next    = cnt_reg;

    case (state_reg)
      S_MUL: begin
        acc_next    = mul_sum;
        mcand_next  = mcand_reg << 1;
        mplier_next = mplier_reg >> 1;
        cnt_next    = cnt_reg + 1'b1;
        // Always runs the full WIDTH iterations; no early exit on mplier==0.
        if (cnt_reg == CNT_LAST) begin
          state_next  = S_DONE;
          result_next = mul_sum;
          zero_next   = (mul_sum == '0);
          ovf_next    = 1'b0;
          bad_next    = 1'b0;
        end
      end
      S_DONE: begin
        if (out_ready && !in_valid) state_next = S_IDLE;
      end
      default: ;
    endcase

    // Accept overrides the drain-to-IDLE so back-to-back ops stay in DONE.
    if (accept) begin
      if (is_mul) begin
        state_next  = S_MUL;
        mcand_next  = a;
        mplier_next = b;
        acc_next    = '0;
        cnt_next    = '0;
      end else begin
        state_next  = S_DONE;
        result_next = alu_res;
        zero_next   = (alu_res == '0);
        ovf_next    = alu_ovf;
        bad_next    = alu_bad;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg  <= S_IDLE;
      result_reg <= '0;
      zero_reg   <= 1'b0;
      ovf_reg    <= 1'b0;
      bad_reg    <= 1'b0;
      mcand_reg  <= '0;
      mplier_reg <= '0;
      acc_reg    <= '0;
      cnt_reg    <= '0;
    end else begin
      state_reg  <= state_next;
      result_reg <= result_next;
      zero_reg   <= zero_next;
      ovf_reg    <= ovf_next;
      bad_reg    <= bad_next;
      mcand_reg  <= mcand_next;
      mplier_reg <= mplier_next;
      acc_reg    <= acc_next;
      cnt_reg    <= cnt_next;
    end
  end

endmodule
